// File: rtl/seq_detect_ctrl_if.sv
// Word-in / count-out handshake bundle for seq_detect_ctrl, plus the pattern
// sideband that is captured together with each accepted word.
interface seq_detect_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic [2:0]       pattern;
  logic             m_valid;
  logic             m_ready;
  logic [CW-1:0]    m_count;

  modport slave (
    input  s_valid, s_data, pattern, m_ready,
    output s_ready, m_valid, m_count
  );

  modport master (
    output s_valid, s_data, pattern, m_ready,
    input  s_ready, m_valid, m_count
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Serializes each word MSB first and counts overlapping 3-bit pattern matches; one bit/cycle, result held until taken.
// Optional macro SEQ_DETECT_CTRL_CROSS_WORD_EN keeps match history across words so matches may span boundaries.
module seq_detect_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_ctrl_if.slave  io,
  output logic              bit_out,
  output logic              match_pulse,
  output logic              busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

`ifdef SEQ_DETECT_CTRL_CROSS_WORD_EN
  localparam bit CROSS_WORD = 1'b1;
`else
  localparam bit CROSS_WORD = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic [1:0]       hist;
  logic [1:0]       fill;
  logic [IW-1:0]    bit_idx;
  logic [2:0]       pat_q;
  logic [CW-1:0]    cnt;

  logic s_ready_c;
  logic m_valid_c;
  logic accept;
  logic shift_en;
  logic last_bit;

  assign shift_en = (state == SHIFT);
  assign accept   = (state == IDLE) && io.s_valid;
  assign last_bit = (bit_idx == IW'(WIDTH - 1));

  // fill[1] marks that two earlier bits are already in hist
  assign bit_out     = shift_en & sreg[WIDTH-1];
  assign match_pulse = shift_en && fill[1] && ({hist, bit_out} == pat_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    s_ready_c = 1'b0;
    m_valid_c = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        s_ready_c = 1'b1;
        busy      = 1'b0;
        if (io.s_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_nx = REPORT;
      end
      REPORT: begin
        m_valid_c = 1'b1;
        if (io.m_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      hist    <= '0;
      fill    <= '0;
      bit_idx <= '0;
      pat_q   <= '0;
      cnt     <= '0;
    end else if (accept) begin
      sreg    <= io.s_data;
      pat_q   <= io.pattern;
      cnt     <= '0;
      bit_idx <= '0;
      if (!CROSS_WORD) begin
        hist <= '0;
        fill <= '0;
      end
    end else if (shift_en) begin
      sreg    <= {sreg[WIDTH-2:0], 1'b0};
      hist    <= {hist[0], bit_out};
      bit_idx <= bit_idx + 1'b1;
      if (!fill[1]) fill <= fill + 2'd1;
      if (match_pulse) cnt <= cnt + 1'b1;
    end
  end

  assign io.s_ready = s_ready_c;
  assign io.m_valid = m_valid_c;
  assign io.m_count = cnt;
endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, gives the number of data bits per word; legal range is 4..32.
REQ-002 Port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port s_valid, input, 1 bit: an input word is offered.
REQ-005 Port s_ready, output, 1 bit: the block can accept a word.
REQ-006 Port s_data, input, WIDTH bits: the word to scan, serialized MSB first.
REQ-007 Port pattern, input, 3 bits: the target sequence; pattern[2] is the oldest bit.
REQ-008 Port bit_out, output, 1 bit: the serial bit currently presented to the detector.
REQ-009 Port match_pulse, output, 1 bit: Mealy match indication for the current bit.
REQ-010 Port m_valid, output, 1 bit: a result is available.
REQ-011 Port m_ready, input, 1 bit: the consumer accepts the result.
REQ-012 Port m_count, output, $clog2(WIDTH+1) bits: number of matches found in the word.
REQ-013 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The FSM shall have exactly three states, IDLE, SHIFT and REPORT, with s_ready = (state==IDLE).
REQ-015 In IDLE, s_valid=1 shall load s_data into the shift register, capture pattern, clear the count and bit index, and move to SHIFT on the same edge.
REQ-016 In SHIFT, the block shall present one bit per cycle on bit_out (s_data[WIDTH-1] first) for exactly WIDTH cycles, then move to REPORT.
REQ-017 Matching shall be overlapping: match_pulse = 1 when {hist[1:0], bit_out} equals the captured pattern and at least 2 earlier bits of the same word have been shifted.
REQ-018 match_pulse shall be combinational and valid only in SHIFT; it shall be 0 in IDLE and REPORT.
REQ-019 m_count shall increment on each edge where match_pulse=1; the maximum value is WIDTH-2, so no saturation logic is needed.
REQ-020 hist shall shift in bit_out on every SHIFT cycle and shall be cleared on word accept.
REQ-021 In REPORT, m_valid=1 and m_count shall be held stable until m_valid&&m_ready, and the block shall then return to IDLE on that edge.
REQ-022 Latency: for a word accepted at edge N, bits appear in cycles N+1..N+WIDTH, m_valid rises in cycle N+WIDTH+1, and the next accept is possible no earlier than the edge after the handshake.
REQ-023 Changes on pattern or s_data after the accept edge shall have no effect on the word in flight.
REQ-024 m_ready=1 while the state is not REPORT shall be ignored.

Reset
REQ-025 When rst=1 at a clock edge: state=IDLE; the shift register, hist, bit index, captured pattern and m_count shall be 0; m_valid=0 and bit_out=0.
REQ-026 rst shall take priority over any handshake in the same cycle, and a reset during SHIFT or REPORT shall discard the word with no m_valid.
REQ-027 After reset is released, s_ready shall be 1 in the first cycle.

Configuration
REQ-028 Macro SEQ_DETECT_CTRL_CROSS_WORD_EN: when defined, hist and its fill count shall be kept across words instead of being cleared on accept, so matches can span word boundaries. Reset still clears them.
REQ-029 When SEQ_DETECT_CTRL_CROSS_WORD_EN is undefined, every word shall be scanned independently as described in REQ-017 and REQ-020.

Verification
REQ-030 WIDTH=8, pattern=101, s_data=8'b10101010 -> match_pulse on bits 3, 5 and 7; m_count=3; m_valid in cycle N+9.
REQ-031 pattern=100, s_data=8'b10010010 -> m_count=2; bit_out sequence is 1,0,0,1,0,0,1,0.
REQ-032 m_ready held low for 5 cycles in REPORT -> m_valid=1, m_count constant and s_ready=0 throughout; IDLE on the cycle after m_ready=1.
REQ-033 Word 8'b00000010 then word 8'b10000000 with pattern=101 -> m_count=0 and 0 with the macro undefined; 0 and 1 with SEQ_DETECT_CTRL_CROSS_WORD_EN defined.
REQ-034 rst asserted in the 4th SHIFT cycle -> next cycle is IDLE, s_ready=1, m_valid never asserted, and the following word gives the correct independent count.
REQ-035 pattern changed from 101 to 111 one cycle after accept, with s_data=8'b10100000 -> m_count=1.
